// File: rtl/bloco_controle.sv
// Traffic-light controller for a pedestrian crossing with a night blink mode.
// Drives the timer datapath (load/clear) and the vehicle/pedestrian lamps.
module bloco_controle #(
    parameter int N_PISCA = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       botao,
    input  logic       noturno,
    input  logic       fim_7s,
    input  logic       fim_5s,
    input  logic       fim_05s,
    output logic       load_Reg7s,
    output logic       load_Reg5s,
    output logic       load_Reg05s,
    output logic       clear_Reg7s,
    output logic       clear_Reg5s,
    output logic       clear_Reg05s,
    output logic       car_verde,
    output logic       car_amarelo,
    output logic       car_vermelho,
    output logic       ped_verde,
    output logic       ped_vermelho,
    output logic [2:0] estado,
    output logic       pedido_pendente
);

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        VERDE    = 3'd1,
        AMARELO  = 3'd2,
        VERMELHO = 3'd3,
        PISCA    = 3'd4,
        NOTURNO  = 3'd5
    } state_t;

    localparam logic [3:0] N_LIM = 4'(N_PISCA);

    state_t     state;
    logic       pisca_on;
    logic [3:0] blink_cnt;
    logic [3:0] blink_next;

    assign blink_next = blink_cnt + 4'd1;
    assign estado     = state;

    // State, blink flag, blink counter and latched pedestrian request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= INIT;
            pisca_on        <= 1'b0;
            blink_cnt       <= 4'd0;
            pedido_pendente <= 1'b0;
        end else begin
            case (state)
                INIT: state <= VERDE;
                VERDE: begin
                    if (noturno) begin
                        state    <= NOTURNO;
                        pisca_on <= 1'b1;
                    end else if (fim_7s && pedido_pendente) begin
                        state <= AMARELO;
                    end
                end
                AMARELO: begin
                    if (fim_5s) state <= VERMELHO;
                end
                VERMELHO: begin
                    if (fim_7s) begin
                        state     <= PISCA;
                        pisca_on  <= 1'b1;
                        blink_cnt <= 4'd0;
                    end
                end
                PISCA: begin
                    if (fim_05s) begin
                        pisca_on <= ~pisca_on;
                        if (blink_next == N_LIM) begin
                            state     <= VERDE;
                            blink_cnt <= 4'd0;
                        end else begin
                            blink_cnt <= blink_next;
                        end
                    end
                end
                NOTURNO: begin
                    if (!noturno) state <= INIT;
                    else if (fim_05s) pisca_on <= ~pisca_on;
                end
                default: state <= INIT;
            endcase

            // Entering VERMELHO serves the request, so its clear beats a new press.
            if (state == AMARELO && fim_5s)
                pedido_pendente <= 1'b0;
            else if (botao && (state == INIT || state == VERDE || state == AMARELO))
                pedido_pendente <= 1'b1;
        end
    end

    always_comb begin
        load_Reg7s   = 1'b0;
        load_Reg5s   = 1'b0;
        load_Reg05s  = 1'b0;
        clear_Reg7s  = 1'b0;
        clear_Reg5s  = 1'b0;
        clear_Reg05s = 1'b0;
        car_verde    = 1'b0;
        car_amarelo  = 1'b0;
        car_vermelho = 1'b0;
        ped_verde    = 1'b0;
        ped_vermelho = 1'b0;
        case (state)
            INIT: begin
                car_vermelho = 1'b1;
                ped_vermelho = 1'b1;
                clear_Reg7s  = 1'b1;
                clear_Reg5s  = 1'b1;
                clear_Reg05s = 1'b1;
            end
            VERDE: begin
                car_verde    = 1'b1;
                ped_vermelho = 1'b1;
                load_Reg7s   = 1'b1;
                clear_Reg7s  = noturno | (fim_7s & pedido_pendente);
                clear_Reg05s = noturno;
            end
            AMARELO: begin
                car_amarelo  = 1'b1;
                ped_vermelho = 1'b1;
                load_Reg5s   = 1'b1;
                clear_Reg5s  = fim_5s;
            end
            VERMELHO: begin
                car_vermelho = 1'b1;
                ped_verde    = 1'b1;
                load_Reg7s   = 1'b1;
                clear_Reg7s  = fim_7s;
                clear_Reg05s = fim_7s;
            end
            PISCA: begin
                car_vermelho = 1'b1;
                ped_vermelho = pisca_on;
                load_Reg05s  = 1'b1;
                clear_Reg05s = fim_05s;
            end
            NOTURNO: begin
                car_amarelo  = pisca_on;
                load_Reg05s  = 1'b1;
                clear_Reg05s = fim_05s;
            end
            // Illegal codes look like INIT for the single cycle before recovery.
            default: begin
                car_vermelho = 1'b1;
                ped_vermelho = 1'b1;
                clear_Reg7s  = 1'b1;
                clear_Reg5s  = 1'b1;
                clear_Reg05s = 1'b1;
            end
        endcase
    end

endmodule
